// File: rtl/alu_result_fifo.sv
// Registered output stage for the divider/ALU result path.
// A small first-word-fall-through FIFO holds {status, result} pairs and
// hands them to the consumer.  Alongside it sit sticky status flags, a
// sticky overrun flag and a saturating error counter.
//
// Handshake: a write is accepted on a rising edge when i_valid && o_ready;
// a pop happens on a rising edge when i_rd && o_valid.  o_ready and o_valid
// are decoded from the count register only, never from i_valid or i_rd.
module alu_result_fifo #(
    parameter int M     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_valid,
    input  logic [M-1:0]               i_result,
    input  logic [3:0]                 i_status,
    output logic                       o_ready,
    input  logic                       i_rd,
    output logic                       o_valid,
    output logic [M-1:0]               o_result,
    output logic [3:0]                 o_status,
    output logic [$clog2(DEPTH):0]     o_count,
    output logic [3:0]                 o_sticky,
    output logic                       o_overrun,
    output logic [7:0]                 o_err_cnt,
    input  logic                       i_clr_sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = M + 4;

    logic [EW-1:0] mem_q [DEPTH];
    logic [EW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [3:0]    sticky_q, sticky_d;
    logic          overrun_q, overrun_d;
    logic [7:0]    err_cnt_q, err_cnt_d;

    logic          full;
    logic          empty;
    logic          wr_acc;
    logic          rd_acc;
    logic [7:0]    err_base;
    logic [EW-1:0] head;

    // Handshake decode from registered state plus the two acceptance strobes.
    always_comb begin
        full   = (count_q == CW'(DEPTH));
        empty  = (count_q == '0);
        wr_acc = i_valid && !full;
        rd_acc = i_rd && !empty;
    end

    // Next-state for storage, pointers, count, sticky flags and error counter.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        err_base = i_clr_sticky ? 8'd0 : err_cnt_q;

        if (wr_acc) begin
            mem_d[wr_ptr_q] = {i_status, i_result};
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_acc) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (wr_acc && !rd_acc) begin
            count_d = count_q + CW'(1);
        end else if (rd_acc && !wr_acc) begin
            count_d = count_q - CW'(1);
        end

        // A clear in the same cycle as a new event still records that event.
        sticky_d  = (i_clr_sticky ? 4'd0 : sticky_q) | (wr_acc ? i_status : 4'd0);
        overrun_d = (i_clr_sticky ? 1'b0 : overrun_q) | (i_valid && full);
        err_cnt_d = err_base;
        if (wr_acc && (i_status[0] || i_status[3]) && (err_base != 8'hFF)) begin
            err_cnt_d = err_base + 8'd1;
        end
    end

    // Control state register; reset discards all held entries.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            sticky_q  <= '0;
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            sticky_q  <= sticky_d;
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    // Entry storage; contents are don't-care while outside the valid window.
    always_ff @(posedge i_clk) begin
        mem_q <= mem_d;
    end

    // Head-of-queue presentation, zeroed while the FIFO is empty.
    always_comb begin
        head      = mem_q[rd_ptr_q];
        o_ready   = !full;
        o_valid   = !empty;
        o_result  = empty ? '0 : head[M-1:0];
        o_status  = empty ? 4'd0 : head[EW-1:M];
        o_count   = count_q;
        o_sticky  = sticky_q;
        o_overrun = overrun_q;
        o_err_cnt = err_cnt_q;
    end

endmodule
